// File: rtl/psum_issuer_if.sv
// rtl/psum_issuer_if.sv - vector intake and accumulator-side handshake bundle for psum_issuer
interface psum_issuer_if #(
  parameter int W_IN  = 18,
  parameter int BEATS = 2
);
  logic                  vec_valid;
  logic                  vec_ready;
  logic [BEATS*W_IN-1:0] vec_data;
  logic                  out_valid;
  logic [W_IN-1:0]       partial_sum;
  logic                  result_valid;

  // environment side: supplies vectors and the accumulator completion pulse
  modport master (
    output vec_valid, vec_data, result_valid,
    input  vec_ready, out_valid, partial_sum
  );

  // issuer side
  modport slave (
    input  vec_valid, vec_data, result_valid,
    output vec_ready, out_valid, partial_sum
  );
endinterface

// File: rtl/psum_issuer.sv
// rtl/psum_issuer.sv - serialises a packed vector of partial sums into back-to-back accumulator beats
module psum_issuer #(
  parameter int W_IN        = 18,
  parameter int BEATS       = 2,
  parameter bit WAIT_RESULT = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  psum_issuer_if.slave bus,
  output logic         busy,
  output logic [15:0]  vec_count,
  output logic         err_spurious
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  localparam int            CW        = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  logic [1:0]            state;
  logic [CW-1:0]         beat;     // index of the beat currently on partial_sum
  logic [BEATS*W_IN-1:0] pending;  // beats not yet presented, next one in the low slice

  logic handshake;
  logic last_beat;
  logic completion;
  logic spurious;

  assign bus.vec_ready = (state == IDLE);
  assign busy          = (state != IDLE);

  // decode handshake, completion and unexpected result pulses from the current state
  always_comb begin
    handshake  = bus.vec_valid & bus.vec_ready;
    last_beat  = (state == SEND) && (beat == LAST_BEAT);
    completion = 1'b0;
    spurious   = 1'b0;
    if (WAIT_RESULT) begin
      completion = bus.result_valid && (last_beat || (state == WAIT));
      spurious   = bus.result_valid && ((state == IDLE) || ((state == SEND) && !last_beat));
    end else begin
      completion = last_beat;
      spurious   = bus.result_valid;
    end
  end

  // vector FSM and registered beat outputs; beat 0 is loaded straight from vec_data at the handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      beat            <= '0;
      pending         <= '0;
      bus.out_valid   <= 1'b0;
      bus.partial_sum <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (handshake) begin
            state           <= SEND;
            beat            <= '0;
            bus.out_valid   <= 1'b1;
            bus.partial_sum <= bus.vec_data[W_IN-1:0];
            pending         <= bus.vec_data >> W_IN;
          end
        end
        SEND: begin
          if (last_beat) begin
            bus.out_valid   <= 1'b0;
            bus.partial_sum <= '0;
            // a result pulse coinciding with the last beat already completes the vector
            if (!WAIT_RESULT || bus.result_valid) begin
              state <= IDLE;
            end else begin
              state <= WAIT;
            end
          end else begin
            beat            <= beat + CW'(1);
            bus.partial_sum <= pending[W_IN-1:0];
            pending         <= pending >> W_IN;
          end
        end
        WAIT: begin
          if (bus.result_valid) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // completed-vector counter and sticky spurious-result flag
  always_ff @(posedge clk) begin
    if (rst) begin
      vec_count    <= 16'd0;
      err_spurious <= 1'b0;
    end else begin
      if (completion) begin
        vec_count <= vec_count + 16'd1;
      end
      if (spurious) begin
        err_spurious <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_psum_issuer.sv
// tb/tb_psum_issuer.sv - scoreboard bench for psum_issuer in wait-for-result and free-running modes
module tb_psum_issuer;

  localparam int W = 18;
  localparam int B = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  psum_issuer_if #(.W_IN(W), .BEATS(B)) bus_a ();
  psum_issuer_if #(.W_IN(W), .BEATS(B)) bus_b ();

  logic        busy_a, busy_b, err_a, err_b;
  logic [15:0] cnt_a, cnt_b;

  psum_issuer #(.W_IN(W), .BEATS(B), .WAIT_RESULT(1'b1)) u_wait (
    .clk(clk), .rst(rst), .bus(bus_a),
    .busy(busy_a), .vec_count(cnt_a), .err_spurious(err_a)
  );

  psum_issuer #(.W_IN(W), .BEATS(B), .WAIT_RESULT(1'b0)) u_free (
    .clk(clk), .rst(rst), .bus(bus_b),
    .busy(busy_b), .vec_count(cnt_b), .err_spurious(err_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] q_a[$];
  logic [W-1:0] q_b[$];
  logic [W:0]   q_sum_b[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // present a vector to the wait-mode issuer (caller guarantees vec_ready) and record its beats
  task automatic offer_a(input logic [B*W-1:0] d);
    bus_a.vec_valid = 1'b1;
    bus_a.vec_data  = d;
    for (int k = 0; k < B; k++) q_a.push_back(d[k*W +: W]);
    step();
    bus_a.vec_valid = 1'b0;
    bus_a.vec_data  = {W'($urandom), W'($urandom)};
  endtask

  // wait-mode output monitor: every valid beat must match the scoreboard head
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_a.out_valid) begin
        if (q_a.size() == 0) check("a_unexpected_beat", 32'(bus_a.partial_sum), 32'hDEAD);
        else                 check("a_beat", 32'(bus_a.partial_sum), 32'(q_a.pop_front()));
      end else begin
        check("a_idle_psum", 32'(bus_a.partial_sum), 32'd0);
      end
    end
  end

  logic [W:0] acc_b = '0;
  int         idx_b = 0;

  // free-mode output monitor: beat order plus the accumulated sum per vector
  always @(negedge clk) begin
    if (!rst && bus_b.out_valid) begin
      if (q_b.size() == 0) begin
        check("b_unexpected_beat", 32'(bus_b.partial_sum), 32'hDEAD);
      end else begin
        check("b_beat", 32'(bus_b.partial_sum), 32'(q_b.pop_front()));
        acc_b = acc_b + (W+1)'(bus_b.partial_sum);
        idx_b++;
        if (idx_b == B) begin
          if (q_sum_b.size() == 0) check("b_unexpected_sum", 32'(acc_b), 32'hDEAD);
          else                     check("b_sum", 32'(acc_b), 32'(q_sum_b.pop_front()));
          acc_b = '0;
          idx_b = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_a.vec_valid = 1'b0; bus_a.vec_data = '0; bus_a.result_valid = 1'b0;
    bus_b.vec_valid = 1'b0; bus_b.vec_data = '0; bus_b.result_valid = 1'b0;

    // reset state
    rst = 1'b1;
    repeat (3) step();
    check("rst_ready_a", 32'(bus_a.vec_ready), 32'd1);
    check("rst_valid_a", 32'(bus_a.out_valid), 32'd0);
    check("rst_psum_a", 32'(bus_a.partial_sum), 32'd0);
    check("rst_cnt_a", 32'(cnt_a), 32'd0);
    check("rst_err_a", 32'(err_a), 32'd0);
    check("rst_busy_a", 32'(busy_a), 32'd0);
    check("rst_ready_b", 32'(bus_b.vec_ready), 32'd1);
    rst = 1'b0;

    // basic vector, completion via a result pulse from WAIT
    offer_a({18'h00002, 18'h00001});
    check("t2_busy", 32'(busy_a), 32'd1);
    check("t2_ready_beat0", 32'(bus_a.vec_ready), 32'd0);
    step();
    check("t2_ready_beat1", 32'(bus_a.vec_ready), 32'd0);
    step();
    check("t2_wait_ready", 32'(bus_a.vec_ready), 32'd0);
    check("t2_wait_valid", 32'(bus_a.out_valid), 32'd0);
    step();
    check("t2_still_wait", 32'(bus_a.vec_ready), 32'd0);
    check("t2_cnt_before", 32'(cnt_a), 32'd0);
    bus_a.result_valid = 1'b1;
    step();
    bus_a.result_valid = 1'b0;
    check("t2_ready_after", 32'(bus_a.vec_ready), 32'd1);
    check("t2_cnt", 32'(cnt_a), 32'd1);
    check("t2_drained", 32'(q_a.size()), 32'd0);

    // result pulse coinciding with the last beat skips WAIT
    offer_a({18'h3FFFF, 18'h00ABC});
    step();
    check("t3_last_valid", 32'(bus_a.out_valid), 32'd1);
    bus_a.result_valid = 1'b1;
    step();
    bus_a.result_valid = 1'b0;
    check("t3_ready", 32'(bus_a.vec_ready), 32'd1);
    check("t3_cnt", 32'(cnt_a), 32'd2);
    check("t3_no_err", 32'(err_a), 32'd0);
    step();
    check("t3_cnt_once", 32'(cnt_a), 32'd2);

    // result pulse in IDLE is spurious and sticky
    bus_a.result_valid = 1'b1;
    step();
    bus_a.result_valid = 1'b0;
    check("t5_err", 32'(err_a), 32'd1);
    check("t5_cnt", 32'(cnt_a), 32'd2);
    check("t5_ready", 32'(bus_a.vec_ready), 32'd1);
    offer_a({18'h12345, 18'h2AAAA});
    repeat (2) step();
    bus_a.result_valid = 1'b1;
    step();
    bus_a.result_valid = 1'b0;
    check("t5_cnt_after", 32'(cnt_a), 32'd3);
    check("t5_err_sticky", 32'(err_a), 32'd1);

    // reset during the first beat drops the vector
    offer_a({18'h00006, 18'h00005});
    check("t6_beat0", 32'(bus_a.out_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    q_a.delete();
    check("t6_valid", 32'(bus_a.out_valid), 32'd0);
    check("t6_psum", 32'(bus_a.partial_sum), 32'd0);
    check("t6_ready", 32'(bus_a.vec_ready), 32'd1);
    check("t6_cnt", 32'(cnt_a), 32'd0);
    check("t6_err", 32'(err_a), 32'd0);
    offer_a({18'h00008, 18'h00007});
    step();
    bus_a.result_valid = 1'b1;
    step();
    bus_a.result_valid = 1'b0;
    check("t6_cnt_after", 32'(cnt_a), 32'd1);
    check("t6_drained", 32'(q_a.size()), 32'd0);

    // free-running stream: 500 vectors with vec_valid held high
    begin
      int accepted = 0;
      logic [B*W-1:0] d;
      bus_b.vec_valid = 1'b1;
      for (int c = 0; c <= 3 * 500; c++) begin
        check("b_pattern_valid", 32'(bus_b.out_valid), 32'((c % 3) != 0));
        check("b_pattern_ready", 32'(bus_b.vec_ready), 32'((c % 3) == 0));
        if (bus_b.vec_ready) begin
          if (accepted < 500) begin
            if (accepted == 0) d = {18'h3FFFF, 18'h3FFFF};
            else               d = {W'($urandom), W'($urandom)};
            bus_b.vec_data = d;
            q_b.push_back(d[W-1:0]);
            q_b.push_back(d[2*W-1:W]);
            q_sum_b.push_back((W+1)'(d[W-1:0]) + (W+1)'(d[2*W-1:W]));
            accepted++;
          end else begin
            bus_b.vec_valid = 1'b0;
          end
        end else begin
          bus_b.vec_data = {W'($urandom), W'($urandom)};
        end
        step();
      end
      check("b_cnt", 32'(cnt_b), 32'd500);
      check("b_no_err", 32'(err_b), 32'd0);
      check("b_drained", 32'(q_sum_b.size()), 32'd0);
    end

    // any result pulse is spurious without waiting
    bus_b.result_valid = 1'b1;
    step();
    bus_b.result_valid = 1'b0;
    check("b_err", 32'(err_b), 32'd1);
    check("b_cnt_hold", 32'(cnt_b), 32'd500);
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
